// File: rtl/iq_tx_feeder.sv
// ============================================================================
// Module   : iq_tx_feeder
// Purpose  : Buffers CPU/DMA I/Q pairs in a FWFT FIFO and releases one pair
//            per decimated-rate tick as a held value plus a one-cycle ce.
//            Optional macro IQ_TX_FEEDER_UNDERRUN_CNT_EN adds o_underrun_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iq_tx_feeder #(
    parameter int DW          = 16,
    parameter int DEPTH       = 64,
    parameter int RATE_DIV    = 1625,
    parameter int START_LEVEL = 32
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     i_enable,
    input  logic                     i_flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [2*DW-1:0]          s_data,
    output logic [DW-1:0]            o_xval,
    output logic [DW-1:0]            o_yval,
    output logic                     o_ce,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_running,
    output logic                     o_underrun
`ifdef IQ_TX_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]              o_underrun_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(RATE_DIV);

    localparam logic [LW-1:0] C_DEPTH_LV = LW'(DEPTH);
    localparam logic [LW-1:0] C_START_LV = LW'(START_LEVEL);
    localparam logic [CW-1:0] C_CNT_MAX  = CW'(RATE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   xval_q, xval_d;
    logic [DW-1:0]   yval_q, yval_d;
    logic            ce_q, ce_d;
    logic            und_q, und_d;

    logic [2*DW-1:0] mem [DEPTH];
    logic [2*DW-1:0] w_rd_data;
    logic            w_wr;
    logic            w_pop;
    logic            w_tick;

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: contents gated by level)
    // ------------------------------------------------------------------
    assign s_ready   = (level_q < C_DEPTH_LV) && !i_flush;
    assign w_wr      = s_valid && s_ready;
    assign w_rd_data = mem[rd_ptr_q];

    always_ff @(posedge sys_clk) begin
        if (w_wr) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (w_wr) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output-rate counter: free-runs outside IDLE, parked at 0 inside it
    // ------------------------------------------------------------------
    assign w_tick = (state_q != ST_IDLE) && (cnt_q == C_CNT_MAX);

    always_comb begin
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == C_CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Streaming state machine; disable beats flush, flush beats run logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
        xval_d  = xval_q;
        yval_d  = yval_q;
        ce_d    = 1'b0;
        und_d   = 1'b0;

        if (!i_enable) begin
            state_d = ST_IDLE;
            xval_d  = '0;
            yval_d  = '0;
        end else if (i_flush) begin
            state_d = ST_PRIME;
            if (w_tick) begin
                ce_d   = 1'b1;
                xval_d = '0;
                yval_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    // Keep the interpolator fed with zeros while filling
                    if (w_tick) begin
                        ce_d   = 1'b1;
                        xval_d = '0;
                        yval_d = '0;
                    end
                    if (level_q >= C_START_LV) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        ce_d = 1'b1;
                        if (level_q != '0) begin
                            w_pop  = 1'b1;
                            xval_d = w_rd_data[2*DW-1:DW];
                            yval_d = w_rd_data[DW-1:0];
                        end else begin
                            xval_d  = '0;
                            yval_d  = '0;
                            und_d   = 1'b1;
                            state_d = ST_PRIME;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    xval_d  = '0;
                    yval_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            xval_q   <= '0;
            yval_q   <= '0;
            ce_q     <= 1'b0;
            und_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            xval_q   <= xval_d;
            yval_q   <= yval_d;
            ce_q     <= ce_d;
            und_q    <= und_d;
        end
    end

    assign o_xval     = xval_q;
    assign o_yval     = yval_q;
    assign o_ce       = ce_q;
    assign o_level    = level_q;
    assign o_running  = (state_q == ST_RUN);
    assign o_underrun = und_q;

`ifdef IQ_TX_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (i_flush) begin
            ucnt_d = '0;
        end else if (und_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign o_underrun_cnt = ucnt_q;
`endif

endmodule

`default_nettype wire
